// File: rtl/if_fetch.sv
// Instruction-fetch stage: direct-mapped one-word-line I-cache, byte-serial refill, jump abort.
// Hits return combinationally; stall[1] freezes the visible outputs from the last unstalled cycle.
module if_fetch #(
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [5:0]        stall,
  input  logic              jump_flag_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rdy_i,
  input  logic [7:0]        mem_byte_i
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t              state, state_nxt;
  logic [1:0]          byte_cnt, byte_cnt_nxt;
  logic [ADDR_W-1:2]   miss_pc;
  logic [23:0]         fill_buf;
  logic [LINES-1:0]    valid;
  logic [31:0]         line_data [LINES];
  logic [TAG_W-1:0]    line_tag  [LINES];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [IDX_W-1:0]    miss_idx;
  logic [ADDR_W-1:0]   pc_word;
  logic                hit;

  logic                latch_miss, buf_we, fill_we;
  logic                stall_c, valid_c;
  logic [31:0]         inst_c;
  logic [ADDR_W-1:0]   pc_c;

  logic [31:0]         inst_q;
  logic [ADDR_W-1:0]   inst_pc_q;
  logic                inst_valid_q;

  logic                unused_ok;
  assign unused_ok = ^{stall[5:2], stall[0], pc_i[1:0]};

  assign idx      = pc_i[IDX_W+1:2];
  assign tag      = pc_i[ADDR_W-1:IDX_W+2];
  assign miss_idx = miss_pc[IDX_W+1:2];
  assign pc_word  = {pc_i[ADDR_W-1:2], 2'b00};
  assign hit      = valid[idx] && (line_tag[idx] == tag);

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    latch_miss   = 1'b0;
    buf_we       = 1'b0;
    fill_we      = 1'b0;
    stall_c      = 1'b0;
    valid_c      = 1'b0;
    inst_c       = 32'h0;
    pc_c         = '0;
    case (state)
      IDLE: begin
        // A redirect in flight makes the current PC stale: neither deliver nor start a refill.
        if (!jump_flag_i) begin
          if (hit) begin
            valid_c = 1'b1;
            inst_c  = line_data[idx];
            pc_c    = pc_word;
          end else begin
            stall_c      = 1'b1;
            latch_miss   = 1'b1;
            byte_cnt_nxt = 2'd0;
            state_nxt    = FETCH;
          end
        end
      end
      FETCH: begin
        stall_c = 1'b1;
        if (jump_flag_i) begin
          byte_cnt_nxt = 2'd0;
          state_nxt    = IDLE;
        end else if (mem_rdy_i) begin
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            fill_we   = 1'b1;
            state_nxt = IDLE;
          end else begin
            buf_we = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      byte_cnt     <= 2'd0;
      miss_pc      <= '0;
      fill_buf     <= 24'h0;
      valid        <= '0;
      inst_q       <= 32'h0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      if (latch_miss) miss_pc <= pc_i[ADDR_W-1:2];
      if (buf_we) fill_buf[{byte_cnt, 3'b000} +: 8] <= mem_byte_i;
      if (fill_we) valid[miss_idx] <= 1'b1;
      if (!stall[1]) begin
        inst_q       <= inst_c;
        inst_pc_q    <= pc_c;
        inst_valid_q <= valid_c;
      end
    end
  end

  // The last byte goes straight into the line, so the buffer only holds bytes 0..2.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      line_data[miss_idx] <= {mem_byte_i, fill_buf};
      line_tag[miss_idx]  <= miss_pc[ADDR_W-1:IDX_W+2];
    end
  end

  assign mem_req_o    = (state == FETCH);
  assign mem_addr_o   = {miss_pc, 2'b00} + {{(ADDR_W-2){1'b0}}, byte_cnt};
  assign stallreq_o   = rst & stall_c;
  assign inst_o       = stall[1] ? inst_q       : inst_c;
  assign inst_pc_o    = stall[1] ? inst_pc_q    : pc_c;
  assign inst_valid_o = stall[1] ? inst_valid_q : valid_c;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: table of single-cycle hit/jump/stall vectors plus refill, abort and reset sequences.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic [5:0]  stall = 6'h0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rdy_i;
  logic [7:0]  mem_byte_i;

  logic        auto_mem = 1'b1;
  logic        auto_rdy = 1'b0;
  logic [7:0]  auto_byte = 8'h0;
  logic        man_rdy = 1'b0;
  logic [7:0]  man_byte = 8'h0;
  logic        prev_req = 1'b0;
  logic [31:0] addr_log [$];

  int tests = 0;
  int fails = 0;

  if_fetch #(.IDX_W(6), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .stall(stall), .jump_flag_i(jump_flag_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .stallreq_o(stallreq_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rdy_i(mem_rdy_i), .mem_byte_i(mem_byte_i)
  );

  always #5 clk = ~clk;

  assign mem_rdy_i  = auto_mem ? auto_rdy  : man_rdy;
  assign mem_byte_i = auto_mem ? auto_byte : man_byte;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  // Memory with one cycle of initial latency, then one byte per cycle.
  always @(negedge clk) begin
    auto_rdy  = mem_req_o && prev_req;
    auto_byte = auto_rdy ? byte_at(mem_addr_o) : 8'h00;
    if (auto_rdy && auto_mem) addr_log.push_back(mem_addr_o);
    prev_req  = mem_req_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a negedge; returns at #1 after the negedge where inst_valid_o rises.
  task automatic wait_fill(output int stall_cycles, output bit ok);
    stall_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid_o) begin
        ok = 1'b1;
        break;
      end
      if (stallreq_o) stall_cycles++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic fill(input logic [31:0] pc);
    int n;
    bit ok;
    @(negedge clk);
    pc_i = pc;
    #1;
    wait_fill(n, ok);
    check("fill_done", {31'h0, ok}, 32'h1);
    check("fill_inst", inst_o, word_at(pc));
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        jump;
    logic        hold;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_sreq;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int  n;
    bit  ok;

    vecs[0] = '{32'h0, 1'b0, 1'b0, 1'b1, 32'h13,          32'h0, 1'b0};
    vecs[1] = '{32'h4, 1'b0, 1'b0, 1'b1, word_at(32'h4),  32'h4, 1'b0};
    vecs[2] = '{32'h8, 1'b0, 1'b0, 1'b1, word_at(32'h8),  32'h8, 1'b0};
    vecs[3] = '{32'h6, 1'b0, 1'b0, 1'b1, word_at(32'h4),  32'h4, 1'b0};
    vecs[4] = '{32'h4, 1'b1, 1'b0, 1'b0, 32'h0,           32'h0, 1'b0};
    vecs[5] = '{32'hC, 1'b1, 1'b0, 1'b0, 32'h0,           32'h0, 1'b0};
    vecs[6] = '{32'h8, 1'b0, 1'b0, 1'b1, word_at(32'h8),  32'h8, 1'b0};
    vecs[7] = '{32'h0, 1'b0, 1'b1, 1'b1, word_at(32'h8),  32'h8, 1'b0};
    vecs[8] = '{32'h4, 1'b0, 1'b1, 1'b1, word_at(32'h8),  32'h8, 1'b0};
    vecs[9] = '{32'h4, 1'b0, 1'b0, 1'b1, word_at(32'h4),  32'h4, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    check("rst_sreq",  {31'h0, stallreq_o},   32'h0);
    check("rst_mreq",  {31'h0, mem_req_o},    32'h0);
    check("rst_inst",  inst_o,    32'h0);
    check("rst_pc",    inst_pc_o, 32'h0);

    // Cold miss at 0x0
    @(negedge clk);
    rst = 1'b1;
    pc_i = 32'h0;
    addr_log.delete();
    #1;
    wait_fill(n, ok);
    check("cold_done",   {31'h0, ok}, 32'h1);
    check("cold_stalls", n, 32'd6);
    check("cold_nbytes", addr_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check("cold_addr", (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF, i);
    check("cold_inst",  inst_o,    32'h0000_0013);
    check("cold_pc",    inst_pc_o, 32'h0);

    // Hit after fill
    @(negedge clk);
    pc_i = 32'h0;
    #1;
    check("hit_inst",  inst_o, 32'h0000_0013);
    check("hit_valid", {31'h0, inst_valid_o}, 32'h1);
    check("hit_sreq",  {31'h0, stallreq_o},   32'h0);
    check("hit_mreq",  {31'h0, mem_req_o},    32'h0);

    fill(32'h4);
    fill(32'h8);

    // Single-cycle vectors: hits, jump flush, IF stall hold
    foreach (vecs[i]) begin
      @(negedge clk);
      pc_i = vecs[i].pc;
      jump_flag_i = vecs[i].jump;
      stall = {4'b0, vecs[i].hold, 1'b0};
      #1;
      check($sformatf("vec%0d_valid", i), {31'h0, inst_valid_o}, {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d_inst", i),  inst_o,    vecs[i].exp_inst);
      check($sformatf("vec%0d_pc", i),    inst_pc_o, vecs[i].exp_pc);
      check($sformatf("vec%0d_sreq", i),  {31'h0, stallreq_o}, {31'h0, vecs[i].exp_sreq});
      check($sformatf("vec%0d_mreq", i),  {31'h0, mem_req_o},  32'h0);
    end
    jump_flag_i = 1'b0;
    stall = 6'h0;

    // Conflict: 0x100 evicts 0x0
    @(negedge clk);
    pc_i = 32'h100;
    #1;
    check("conf_miss_sreq", {31'h0, stallreq_o}, 32'h1);
    wait_fill(n, ok);
    check("conf_done", {31'h0, ok}, 32'h1);
    check("conf_inst", inst_o, word_at(32'h100));
    @(negedge clk);
    pc_i = 32'h0;
    #1;
    check("conf_evict_sreq",  {31'h0, stallreq_o},   32'h1);
    check("conf_evict_valid", {31'h0, inst_valid_o}, 32'h0);
    wait_fill(n, ok);
    check("conf_refill", inst_o, 32'h13);

    // PC changes mid-fill without a jump: fill completes, nothing delivered meanwhile
    @(negedge clk);
    pc_i = 32'h80;
    #1;
    @(negedge clk);
    pc_i = 32'h4;
    #1;
    check("pchg_sreq",  {31'h0, stallreq_o},   32'h1);
    check("pchg_valid", {31'h0, inst_valid_o}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (!mem_req_o) break;
      @(negedge clk);
      #1;
    end
    check("pchg_fill_end", {31'h0, mem_req_o}, 32'h0);
    check("pchg_hit4", inst_o, word_at(32'h4));
    @(negedge clk);
    pc_i = 32'h80;
    #1;
    check("pchg_hit80_valid", {31'h0, inst_valid_o}, 32'h1);
    check("pchg_hit80", inst_o, word_at(32'h80));

    // Jump abort after 2 bytes at 0x40
    @(negedge clk);
    auto_mem = 1'b0;
    man_rdy = 1'b0;
    pc_i = 32'h40;
    #1;
    check("abort_miss", {31'h0, stallreq_o}, 32'h1);
    @(negedge clk);
    man_rdy = 1'b1;
    man_byte = 8'hAA;
    #1;
    check("abort_addr0", mem_addr_o, 32'h40);
    @(negedge clk);
    man_byte = 8'hBB;
    #1;
    check("abort_addr1", mem_addr_o, 32'h41);
    @(negedge clk);
    jump_flag_i = 1'b1;
    man_byte = 8'hCC;
    #1;
    check("abort_jcyc_mreq", {31'h0, mem_req_o},  32'h1);
    check("abort_jcyc_sreq", {31'h0, stallreq_o}, 32'h1);
    check("abort_jcyc_addr", mem_addr_o, 32'h42);
    @(negedge clk);
    jump_flag_i = 1'b0;
    man_byte = 8'hDD;
    #1;
    check("abort_mreq",    {31'h0, mem_req_o},    32'h0);
    check("abort_nowrite", {31'h0, inst_valid_o}, 32'h0);
    check("abort_remiss",  {31'h0, stallreq_o},   32'h1);
    @(negedge clk);
    man_rdy = 1'b0;
    #1;
    check("abort_cnt_reset", mem_addr_o, 32'h40);
    auto_mem = 1'b1;
    wait_fill(n, ok);
    check("abort_refill_done", {31'h0, ok}, 32'h1);
    check("abort_refill", inst_o, word_at(32'h40));

    // Async reset after 3 bytes of a fill at 0xC0
    @(negedge clk);
    auto_mem = 1'b0;
    pc_i = 32'hC0;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      man_rdy = 1'b1;
      man_byte = byte_at(32'hC0 + i);
    end
    @(negedge clk);
    man_rdy = 1'b0;
    #1;
    check("arst_pre_mreq", {31'h0, mem_req_o}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_mreq",  {31'h0, mem_req_o},    32'h0);
    check("arst_sreq",  {31'h0, stallreq_o},   32'h0);
    check("arst_valid", {31'h0, inst_valid_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    auto_mem = 1'b1;
    pc_i = 32'h0;
    #1;
    check("arst_inval_sreq",  {31'h0, stallreq_o},   32'h1);
    check("arst_inval_valid", {31'h0, inst_valid_o}, 32'h0);
    wait_fill(n, ok);
    check("arst_refill_done", {31'h0, ok}, 32'h1);
    check("arst_refill", inst_o, 32'h13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
